btn_press_classifier: RTL and testbench

//  N-channel push-button front end: synchronises and debounces each raw button, then

---
 rtl/btn_press_classifier.sv | 138 +++++++++++++
 tb/tb_btn_press_classifier.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/btn_press_classifier.sv
// N-channel push-button front end: synchroniser, tick-based debouncer and
// SHORT/LONG press classifier per channel, all sharing one tick divider.
module btn_press_classifier #(
   parameter int N_BTN          = 4,
   parameter int TICK_CYCLES    = 50000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int LONG_TICKS     = 5000,
   parameter bit ACTIVE_LOW     = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] short_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] long_held
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HW = $clog2(LONG_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

   typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

   logic [TW-1:0]    tick_cnt_reg;
   logic             tick;
   logic [N_BTN-1:0] sync1_reg;
   logic [N_BTN-1:0] sync2_reg;
   logic [N_BTN-1:0] sync;

   assign tick = (tick_cnt_reg == TICK_LAST);
   assign sync = sync2_reg ^ {N_BTN{ACTIVE_LOW}};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_reg <= '0;
         sync1_reg    <= '0;
         sync2_reg    <= '0;
      end else begin
         tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);
         sync1_reg    <= btn_in;
         sync2_reg    <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_ch
         logic [DW-1:0] db_cnt_reg;
         logic          level_reg;
         state_t        state_reg, state_next;
         logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
         logic          short_reg, short_next;
         logic          long_reg, long_next;
         logic          held_reg, held_next;

         // Any return to the current level restarts the stability window.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               db_cnt_reg <= '0;
               level_reg  <= 1'b0;
            end else if (sync[gi] == level_reg) begin
               db_cnt_reg <= '0;
            end else if (tick) begin
               if (db_cnt_reg == DB_LAST) begin
                  level_reg  <= sync[gi];
                  db_cnt_reg <= '0;
               end else begin
                  db_cnt_reg <= db_cnt_reg + DW'(1);
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               state_reg    <= IDLE;
               hold_cnt_reg <= '0;
               short_reg    <= 1'b0;
               long_reg     <= 1'b0;
               held_reg     <= 1'b0;
            end else begin
               state_reg    <= state_next;
               hold_cnt_reg <= hold_cnt_next;
               short_reg    <= short_next;
               long_reg     <= long_next;
               held_reg     <= held_next;
            end
         end

         // Release is tested before the threshold tick so it wins a tie.
         always_comb begin
            state_next    = state_reg;
            hold_cnt_next = hold_cnt_reg;
            short_next    = 1'b0;
            long_next     = 1'b0;
            held_next     = held_reg;
            case (state_reg)
               IDLE: begin
                  if (level_reg) begin
                     state_next    = PRESS;
                     hold_cnt_next = '0;
                  end
               end
               PRESS: begin
                  if (!level_reg) begin
                     state_next = IDLE;
                     short_next = 1'b1;
                  end else if (tick) begin
                     if (hold_cnt_reg == HOLD_LAST) begin
                        state_next = LONG;
                        long_next  = 1'b1;
                        held_next  = 1'b1;
                     end else begin
                        hold_cnt_next = hold_cnt_reg + HW'(1);
                     end
                  end
               end
               LONG: begin
                  if (!level_reg) begin
                     state_next = IDLE;
                     held_next  = 1'b0;
                  end
               end
               default: state_next = IDLE;
            endcase
         end

         assign btn_level[gi]   = level_reg;
         assign short_pulse[gi] = short_reg;
         assign long_pulse[gi]  = long_reg;
         assign long_held[gi]   = held_reg;
      end
   endgenerate

endmodule

// File: tb/tb_btn_press_classifier.sv
// Scoreboard bench for btn_press_classifier: expected press events are queued
// as stimulus is applied and matched against observed pulses with latency checks.
module tb_btn_press_classifier;

   localparam int N   = 4;
   localparam int TC  = 4;
   localparam int LT  = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn_in = 4'hF;
   logic [N-1:0] btn_level, short_pulse, long_pulse, long_held;

   btn_press_classifier #(
      .N_BTN(N), .TICK_CYCLES(TC), .DEBOUNCE_TICKS(3), .LONG_TICKS(LT), .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
      .short_pulse(short_pulse), .long_pulse(long_pulse), .long_held(long_held)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int sb_q[$];      // event code: ch*2 + (0 short, 1 long)
   int rise_cyc[N];
   int fall_cyc[N];
   bit long_seen[N];
   bit clear_chk[N];
   logic [N-1:0] lvl_prev = '0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: pulses pop the scoreboard; latencies are measured from level edges.
   always @(negedge clk) begin
      for (int c = 0; c < N; c++) begin
         int e;
         if (clear_chk[c]) begin
            check_val($sformatf("held_clr%0d", c), 32'(long_held[c]), 0);
            clear_chk[c] = 1'b0;
         end
         if (btn_level[c] && !lvl_prev[c]) rise_cyc[c] = cyc;
         if (!btn_level[c] && lvl_prev[c]) begin
            fall_cyc[c] = cyc;
            if (long_seen[c]) clear_chk[c] = 1'b1;
            long_seen[c] = 1'b0;
         end
         if (long_seen[c] && btn_level[c])
            check_val($sformatf("held_on%0d", c), 32'(long_held[c]), 1);
         if (short_pulse[c]) begin
            if (sb_q.size() > 0) e = sb_q.pop_front(); else e = -1;
            check_val("event_short", 32'(c * 2), 32'(e));
            check_val("short_lat", 32'(cyc - fall_cyc[c]), 1);
            $display("cycle %0d: short_pulse[%0d]", cyc, c);
         end
         if (long_pulse[c]) begin
            if (sb_q.size() > 0) e = sb_q.pop_front(); else e = -1;
            check_val("event_long", 32'(c * 2 + 1), 32'(e));
            check_val("long_lat", 32'(cyc - rise_cyc[c]), 32'(LT * TC));
            check_val("held_at_long", 32'(long_held[c]), 1);
            long_seen[c] = 1'b1;
            $display("cycle %0d: long_pulse[%0d]", cyc, c);
         end
      end
      lvl_prev = btn_level;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic hold_btn(input logic [N-1:0] mask, input int ticks);
      @(posedge clk); #1 btn_in = btn_in | mask;
      repeat (ticks * TC) @(posedge clk);
      #1 btn_in = btn_in & ~mask;
   endtask

   initial begin
      int n;
      // 1: reset with all buttons pressed, then debounce to 4'hF
      repeat (3) @(posedge clk);
      #1 check_val("rst_outs", {btn_level, short_pulse, long_pulse, long_held}, 0);
      rst_n = 1'b1;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (btn_level == 4'hF) break;
         check_val("pre_lvl_low", 32'(btn_level), 0);
         n++;
      end
      check_val("rise_cycles", 32'(n), 12);
      @(posedge clk); #1 rst_n = 1'b0; btn_in = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      check_val("rst2_outs", {btn_level, short_pulse, long_pulse, long_held}, 0);
      idle(40);
      $display("test1 done: reset and initial debounce");

      // 2: short press on channel 0
      sb_q.push_back(0);
      hold_btn(4'b0001, 8);
      idle(60);
      $display("test2 done: short press ch0");

      // 3: long press on channel 1
      sb_q.push_back(3);
      hold_btn(4'b0010, 20);
      idle(60);
      $display("test3 done: long press ch1");

      // 4: bouncing channel 2 never settles
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1 btn_in[2] = ~btn_in[2];
         repeat (7) @(posedge clk);
         check_val("bounce_lvl", 32'(btn_level[2]), 0);
      end
      idle(40);
      $display("test4 done: bounce ch2");

      // 5: concurrent short on ch0 and long on ch3
      sb_q.push_back(0);
      sb_q.push_back(7);
      @(posedge clk); #1 btn_in[0] = 1'b1; btn_in[3] = 1'b1;
      repeat (6 * TC) @(posedge clk);
      #1 btn_in[0] = 1'b0;
      repeat (14 * TC) @(posedge clk);
      #1 btn_in[3] = 1'b0;
      idle(60);
      $display("test5 done: concurrent ch0 short / ch3 long");

      // 6: reset mid-press on ch1, button stays held afterwards
      sb_q.push_back(3);
      @(posedge clk); #1 btn_in[1] = 1'b1;
      repeat (6 * TC) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      check_val("rst3_lvl", 32'(btn_level), 0);
      repeat (20 * TC) @(posedge clk);
      #1 btn_in[1] = 1'b0;
      idle(60);
      $display("test6 done: reset mid-press ch1");

      check_val("sb_drain", 32'(sb_q.size()), 0);
      check_val("final_held", 32'(long_held), 0);
      check_val("final_lvl", 32'(btn_level), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
